// File: rtl/gcd_binary_engine.sv
// gcd_binary_engine: binary (Stein) GCD with valid/ready handshakes, abort and iteration count
module gcd_binary_engine #(
  parameter int NBITS = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NBITS-1:0]                  a_in,
  input  logic [NBITS-1:0]                  b_in,
  input  logic                              abort,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NBITS-1:0]                  result,
  output logic [$clog2(2*NBITS+2)-1:0]      cycles
);
  localparam int CNT_W = $clog2(2*NBITS+2);
  localparam int K_W   = $clog2(NBITS+1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [NBITS-1:0] r_a, r_b, r_result, w_diff;
  logic [K_W-1:0]   r_k;
  logic [CNT_W-1:0] r_cnt, r_cycles;
  logic w_a_zero, w_b_zero, w_a_even, w_b_even, w_a_ge_b, w_fin, w_step;
  assign w_a_zero = r_a == '0;
  assign w_b_zero = r_b == '0;
  assign w_a_even = ~r_a[0];
  assign w_b_even = ~r_b[0];
  assign w_a_ge_b = r_a >= r_b;
  // subtract smaller from larger so the difference is never negative
  assign w_diff   = w_a_ge_b ? r_a - r_b : r_b - r_a;
  assign w_fin    = w_a_zero | w_b_zero;
  assign w_step   = r_state == RUN && !abort;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = in_valid ? RUN : IDLE;
      RUN:     w_next = abort ? IDLE : (w_fin ? DONE : RUN);
      DONE:    w_next = (abort || out_ready) ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = r_state == IDLE;
    out_valid = r_state == DONE;
    result    = r_result;
    cycles    = r_cycles;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_k      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cycles <= '0;
    end else if (r_state == IDLE && in_valid) begin
      r_a   <= a_in;
      r_b   <= b_in;
      r_k   <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_a_zero) begin
        r_result <= r_b << r_k;
        r_cycles <= r_cnt + CNT_W'(1);
      end else if (w_b_zero) begin
        r_result <= r_a << r_k;
        r_cycles <= r_cnt + CNT_W'(1);
      end else if (w_a_even && w_b_even) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_k <= r_k + K_W'(1);
      end else if (w_a_even) r_a <= r_a >> 1;
      else if (w_b_even)     r_b <= r_b >> 1;
      else if (w_a_ge_b)     r_a <= w_diff >> 1;
      else                   r_b <= w_diff >> 1;
    end
endmodule
